// File: rtl/instr_decode_if.sv
// rtl/instr_decode_if.sv - decode-stage bus: instruction in, regfile read port, decoded fields out (illegal flag under INSTR_DECODE_ILLEGAL_EN)
interface instr_decode_if;
    logic [31:0] instr;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        is_store;
    logic        is_load;
    logic        is_branch;
    logic        is_jump;
    logic        is_reg;
    logic        is_alu;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] branch_dest;
    logic [4:0]  dest;
    logic [2:0]  func3;
    logic        func7;
`ifdef INSTR_DECODE_ILLEGAL_EN
    logic        illegal;
`endif

    // Decoder side
    modport master (
        input  instr, rdata1, rdata2,
        output raddr1, raddr2,
        output is_store, is_load, is_branch, is_jump, is_reg, is_alu,
        output operand_a, operand_b, branch_dest, dest, func3, func7
`ifdef INSTR_DECODE_ILLEGAL_EN
        , output illegal
`endif
    );

    // Fetch / register file / execute side
    modport slave (
        output instr, rdata1, rdata2,
        input  raddr1, raddr2,
        input  is_store, is_load, is_branch, is_jump, is_reg, is_alu,
        input  operand_a, operand_b, branch_dest, dest, func3, func7
`ifdef INSTR_DECODE_ILLEGAL_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - RV32I decode stage, 1-cycle registered outputs; INSTR_DECODE_ILLEGAL_EN adds registered illegal flag
module instr_decode (
    input  logic           clk_i,
    input  logic           reset_ni,
    instr_decode_if.master bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic        is_store;
        logic        is_load;
        logic        is_branch;
        logic        is_jump;
        logic        is_reg;
        logic        is_alu;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] branch_dest;
        logic [4:0]  dest;
        logic [2:0]  func3;
        logic        func7;
`ifdef INSTR_DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } dec_t;

    dec_t dec_d;
    dec_t dec_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign f3     = bus.instr[14:12];
    assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b  = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign imm_j  = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                     bus.instr[20], bus.instr[30:21], 1'b0};
    assign imm_u  = {bus.instr[31:12], 12'b0};

    // Register-file read addresses go straight out so rdata arrives in the same cycle; parked at x0 in reset
    always_comb begin
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        if (reset_ni) begin
            bus.raddr1 = bus.instr[19:15];
            bus.raddr2 = bus.instr[24:20];
        end
    end

    // Opcode decode; anything unrecognised (including a bad [1:0] quadrant) stays all-zero as a bubble
    always_comb begin
        dec_d = '0;
        case (opcode)
            OPC_JAL: begin
                dec_d.is_jump   = 1'b1;
                dec_d.operand_a = imm_j;
                dec_d.dest      = rd;
            end
            OPC_JALR: begin
                dec_d.is_jump   = 1'b1;
                dec_d.is_reg    = 1'b1;
                dec_d.operand_a = bus.rdata1;
                dec_d.operand_b = imm_i;
                dec_d.dest      = rd;
                dec_d.func3     = f3;
            end
            OPC_BRANCH: begin
                dec_d.is_branch   = 1'b1;
                dec_d.operand_a   = bus.rdata1;
                dec_d.operand_b   = bus.rdata2;
                dec_d.branch_dest = imm_b;
                dec_d.func3       = f3;
            end
            OPC_LOAD: begin
                dec_d.is_load   = 1'b1;
                dec_d.operand_a = bus.rdata1;
                dec_d.operand_b = imm_i;
                dec_d.dest      = rd;
                dec_d.func3     = f3;
            end
            OPC_STORE: begin
                dec_d.is_store    = 1'b1;
                dec_d.operand_a   = bus.rdata1;
                dec_d.operand_b   = bus.rdata2;
                dec_d.branch_dest = imm_s;
                dec_d.func3       = f3;
            end
            OPC_OPIMM: begin
                dec_d.is_alu    = 1'b1;
                dec_d.operand_a = bus.rdata1;
                // Shifts (func3 001/101) carry a 5-bit shamt, not a signed immediate
                dec_d.operand_b = (f3[1:0] == 2'b01) ? {27'd0, bus.instr[24:20]} : imm_i;
                dec_d.dest      = rd;
                dec_d.func3     = f3;
                dec_d.func7     = (f3 == 3'b101) ? bus.instr[30] : 1'b0;
            end
            OPC_OP: begin
                dec_d.is_alu    = 1'b1;
                dec_d.is_reg    = 1'b1;
                dec_d.operand_a = bus.rdata1;
                dec_d.operand_b = bus.rdata2;
                dec_d.dest      = rd;
                dec_d.func3     = f3;
                dec_d.func7     = bus.instr[30];
            end
            OPC_LUI: begin
                // Executed as 0 + imm so the ALU just adds
                dec_d.is_alu    = 1'b1;
                dec_d.operand_b = imm_u;
                dec_d.dest      = rd;
            end
            default: begin
`ifdef INSTR_DECODE_ILLEGAL_EN
                dec_d.illegal = 1'b1;
`endif
            end
        endcase
    end

    // Pipeline register towards execute
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign bus.is_store    = dec_q.is_store;
    assign bus.is_load     = dec_q.is_load;
    assign bus.is_branch   = dec_q.is_branch;
    assign bus.is_jump     = dec_q.is_jump;
    assign bus.is_reg      = dec_q.is_reg;
    assign bus.is_alu      = dec_q.is_alu;
    assign bus.operand_a   = dec_q.operand_a;
    assign bus.operand_b   = dec_q.operand_b;
    assign bus.branch_dest = dec_q.branch_dest;
    assign bus.dest        = dec_q.dest;
    assign bus.func3       = dec_q.func3;
    assign bus.func7       = dec_q.func7;
`ifdef INSTR_DECODE_ILLEGAL_EN
    assign bus.illegal     = dec_q.illegal;
`endif
endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - directed scoreboard bench for instr_decode with a behavioural register file
module tb_instr_decode;
    logic clk;
    logic rst_n;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] rf [32];

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        st, ld, br, jp, rg, al, il;
        logic [31:0] a, b, bd;
        logic [4:0]  dest;
        logic [2:0]  f3;
        logic        f7;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    instr_decode_if bus ();

    instr_decode dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: async read with x0 hard-wired, sync write, cleared while reset is low
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (w_en && w_addr != 5'd0) begin
            rf[w_addr] <= w_data;
        end
    end
    assign bus.rdata1 = (bus.raddr1 == 5'd0) ? 32'd0 : rf[bus.raddr1];
    assign bus.rdata2 = (bus.raddr2 == 5'd0) ? 32'd0 : rf[bus.raddr2];

    function automatic exp_t mk(input string t);
        exp_t r;
        r.st = 0; r.ld = 0; r.br = 0; r.jp = 0; r.rg = 0; r.al = 0; r.il = 0;
        r.a = 0; r.b = 0; r.bd = 0; r.dest = 0; r.f3 = 0; r.f7 = 0;
        r.tag = t;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input exp_t x);
        chk({x.tag, ".is_store"},    32'(bus.is_store),  32'(x.st));
        chk({x.tag, ".is_load"},     32'(bus.is_load),   32'(x.ld));
        chk({x.tag, ".is_branch"},   32'(bus.is_branch), 32'(x.br));
        chk({x.tag, ".is_jump"},     32'(bus.is_jump),   32'(x.jp));
        chk({x.tag, ".is_reg"},      32'(bus.is_reg),    32'(x.rg));
        chk({x.tag, ".is_alu"},      32'(bus.is_alu),    32'(x.al));
        chk({x.tag, ".operand_a"},   bus.operand_a,      x.a);
        chk({x.tag, ".operand_b"},   bus.operand_b,      x.b);
        chk({x.tag, ".branch_dest"}, bus.branch_dest,    x.bd);
        chk({x.tag, ".dest"},        32'(bus.dest),      32'(x.dest));
        chk({x.tag, ".func3"},       32'(bus.func3),     32'(x.f3));
        chk({x.tag, ".func7"},       32'(bus.func7),     32'(x.f7));
`ifdef INSTR_DECODE_ILLEGAL_EN
        chk({x.tag, ".illegal"},     32'(bus.illegal),   32'(x.il));
`endif
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        w_en = 1'b1; w_addr = a; w_data = d;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    // Drive one instruction, check combinational read addresses, then compare the registered decode
    task automatic step(input logic [31:0] ins, input exp_t x, input logic [4:0] r1, input logic [4:0] r2);
        exp_t g;
        @(negedge clk);
        bus.instr = ins;
        #1;
        chk({x.tag, ".raddr1"}, 32'(bus.raddr1), 32'(r1));
        chk({x.tag, ".raddr2"}, 32'(bus.raddr2), 32'(r2));
        sb.push_back(x);
        @(posedge clk);
        #1;
        n_assert++;
        assert (sb.size() == 1) else begin
            n_fail++;
            $error("FAIL %s.scoreboard: observed %0d entries expected 1", x.tag, sb.size());
        end
        if (sb.size() != 0) begin
            g = sb.pop_front();
            check_out(g);
        end
    endtask

    initial begin
        rst_n = 1'b0; w_en = 1'b0; w_addr = 5'd0; w_data = 32'd0;
        bus.instr = 32'h01FF82B3;
        repeat (2) @(posedge clk);
        #1;
        check_out(mk("reset"));
        chk("reset.raddr1", 32'(bus.raddr1), 32'd0);
        chk("reset.raddr2", 32'(bus.raddr2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(5'd31, 32'd12345);
        wr(5'd27, 32'h55);

        e = mk("jal");  e.jp = 1; e.a = 32'd2000; e.dest = 5'd3;
        step(32'h7D0001EF, e, 5'd0, 5'd16);

        e = mk("jalr"); e.jp = 1; e.rg = 1; e.a = 32'd12345; e.b = 32'd2000; e.dest = 5'd2;
        step(32'h7D0F8167, e, 5'd31, 5'd16);

        e = mk("add");  e.al = 1; e.rg = 1; e.a = 32'd12345; e.b = 32'd12345; e.dest = 5'd5;
        step(32'h01FF82B3, e, 5'd31, 5'd31);
        e.tag = "add_hold";
        step(32'h01FF82B3, e, 5'd31, 5'd31);

        e = mk("sub");  e.al = 1; e.rg = 1; e.a = 32'd12345; e.b = 32'd12345; e.dest = 5'd5; e.f7 = 1;
        step(32'h41FF82B3, e, 5'd31, 5'd31);

        e = mk("beq");  e.br = 1; e.a = 32'd12345; e.b = 32'd0; e.bd = 32'hFFFFFFF8;
        step(32'hFE0F8CE3, e, 5'd31, 5'd0);

        e = mk("sw");   e.st = 1; e.a = 32'd0; e.b = 32'd12345; e.bd = 32'hFFFFFFFC; e.f3 = 3'b010;
        step(32'hFFF02E23, e, 5'd0, 5'd31);

        e = mk("lw");   e.ld = 1; e.a = 32'd12345; e.b = 32'hFFFFFFF0; e.dest = 5'd6; e.f3 = 3'b010;
        step(32'hFF0FA303, e, 5'd31, 5'd16);

        e = mk("srai"); e.al = 1; e.a = 32'd12345; e.b = 32'd3; e.dest = 5'd7; e.f3 = 3'b101; e.f7 = 1;
        step(32'h403FD393, e, 5'd31, 5'd3);

        e = mk("addi"); e.al = 1; e.a = 32'd12345; e.b = 32'hFFFFFFFF; e.dest = 5'd8;
        step(32'hFFFF8413, e, 5'd31, 5'd31);

        e = mk("lui");  e.al = 1; e.b = 32'hABCDE000; e.dest = 5'd9;
        step(32'hABCDE4B7, e, 5'd27, 5'd28);

        e = mk("auipc"); e.il = 1;
        step(32'h00001097, e, 5'd0, 5'd0);

        e = mk("ecall"); e.il = 1;
        step(32'h00000073, e, 5'd0, 5'd0);

        e = mk("bad_quadrant"); e.il = 1;
        step(32'h01FF82B0, e, 5'd31, 5'd31);

        e = mk("add2"); e.al = 1; e.rg = 1; e.a = 32'd12345; e.b = 32'd12345; e.dest = 5'd5;
        step(32'h01FF82B3, e, 5'd31, 5'd31);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out(mk("async_rst"));
        chk("async_rst.raddr1", 32'(bus.raddr1), 32'd0);
        chk("async_rst.raddr2", 32'(bus.raddr2), 32'd0);
        @(posedge clk);
        #1;
        check_out(mk("rst_hold"));
        @(negedge clk);
        rst_n = 1'b1;

        e = mk("jal_after_rst"); e.jp = 1; e.a = 32'd2000; e.dest = 5'd3;
        step(32'h7D0001EF, e, 5'd0, 5'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_decode.md
# instr_decode

RV32I instruction decoder stage. Takes one 32-bit instruction and drives combinational register-file read addresses to `regs`. Registers classification flags, ALU/branch operands, destination register and function fields on each clock edge for the execute stage. Sits between fetch and the ALU/LSU/branch unit; `regs` (the register file) is read asynchronously through `raddr1`/`raddr2` and `rdata1`/`rdata2`.

## Interface
Parameters: none.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `instr`  input  32  instruction word
- `rdata1`  input  32  `regs` read data for `raddr1`
- `rdata2`  input  32  `regs` read data for `raddr2`
- `raddr1`  output  5  rs1 address, combinational
- `raddr2`  output  5  rs2 address, combinational
- `is_store`  output  1  STORE (opcode 0100011)
- `is_load`  output  1  LOAD (0000011)
- `is_branch`  output  1  BRANCH (1100011)
- `is_jump`  output  1  JAL (1101111) or JALR (1100111)
- `is_reg`  output  1  register-sourced variant: JALR or OP (0110011)
- `is_alu`  output  1  OP, OP-IMM (0010011) or LUI (0110111)
- `operand_a`  output  32  first operand
- `operand_b`  output  32  second operand
- `branch_dest`  output  32  sign-extended B-immediate (branch) or S-immediate (store)
- `dest`  output  5  rd; 0 for store/branch
- `func3`  output  3  instr[14:12]; 0 for JAL/LUI
- `func7`  output  1  instr[30] for OP, and for OP-IMM shifts (func3 101); else 0

## Operation
- `raddr1` = instr[19:15], `raddr2` = instr[24:20] while reset deasserted; both forced to 0 while reset asserted.
- Per opcode (all outputs not listed are 0):
  - JAL: is_jump; operand_a = sign-extended J-imm {instr[31],instr[19:12],instr[20],instr[30:21],0}; dest.
  - JALR: is_jump, is_reg; operand_a = rdata1; operand_b = sign-extended I-imm; dest; func3.
  - BRANCH: is_branch; operand_a = rdata1; operand_b = rdata2; branch_dest = B-imm; func3.
  - LOAD: is_load; operand_a = rdata1; operand_b = I-imm; dest; func3.
  - STORE: is_store; operand_a = rdata1; operand_b = rdata2 (store data); branch_dest = S-imm; func3.
  - OP-IMM: is_alu; operand_a = rdata1; operand_b = I-imm (shifts: zero-extended instr[24:20]); dest; func3; func7.
  - OP: is_alu, is_reg; operand_a = rdata1; operand_b = rdata2; dest; func3; func7.
  - LUI: is_alu; operand_a = 0; operand_b = {instr[31:12],12'b0}; dest; func3 = 000 (add).
  - Any other opcode (incl. AUIPC, SYSTEM, FENCE): all registered outputs 0 (bubble).
- Immediates are sign-extended from instr[31] to 32 bits.
- `regs` requirement: asynchronous read, x0 reads 0, synchronous write on `w_en`.

## Timing
- Reset asserted: every registered output = 0 immediately (async) and held; `raddr1`/`raddr2` = 0.
- Latency 1 cycle: outputs reflect `instr`/`rdata*` sampled at the rising edge.
- No handshake; decodes a new instruction every cycle; holding `instr` re-decodes identically.
- Reset deassertion mid-stream: first decode on next rising edge.
- Register written in cycle N is visible to decode at edge N+1 via async read.

## Configuration
- `INSTR_DECODE_ILLEGAL_EN`: when defined, adds output `illegal` (1 bit, registered, reset 0), set to 1 for any unsupported opcode or instr[1:0] != 11. When undefined, port absent; unsupported opcodes still produce all-zero outputs.

## Test plan
- Reset low one cycle -> all flags, operands, branch_dest, dest, func3, func7, raddr1, raddr2 = 0.
- JAL instr 0x7D0001EF -> is_jump=1, is_store/is_load/is_branch/is_reg=0, operand_a=2000, dest=3.
- Write x31=12345 via `regs`, then JALR 0x7D0F8167 -> is_jump=1, is_reg=1, operand_a=12345, operand_b=2000, dest=2.
- ADD x5,x31,x31 (0x01FF82B3) -> is_alu=1, is_reg=1, operand_a=operand_b=12345, dest=5, func3=0, func7=0; SUB variant -> func7=1.
- BEQ x31,x0,-8 (0xFE0F8CE3) -> is_branch=1, operand_a=12345, operand_b=0, branch_dest=0xFFFFFFF8, dest=0.
- SW x31,-4(x0) (0xFFF02E23) -> is_store=1, operand_a=0, operand_b=12345, branch_dest=0xFFFFFFFC, func3=010; AUIPC -> all outputs 0.
